// File: rtl/counter_updown_mod.sv
// rtl/counter_updown_mod.sv - up/down counter with modulus, load, wrap/saturate and limit pulses
module counter_updown_mod #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = (2**WIDTH) - 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf,
    output logic             unf
);

    localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0] next_count;
    logic             next_ovf;
    logic             next_unf;
    logic             at_max;
    logic             at_min;
    logic [WIDTH-1:0] load_clamped;

    assign at_max       = (count == MAX_CNT);
    assign at_min       = (count == '0);
    // Loaded values above the modulus are pinned to the top of the range.
    assign load_clamped = (load_val > MAX_CNT) ? MAX_CNT : load_val;

    // Next count and limit pulses: load beats enable, enable beats hold.
    always_comb begin
        next_count = count;
        next_ovf   = 1'b0;
        next_unf   = 1'b0;
        if (load) begin
            next_count = load_clamped;
        end else if (en) begin
            if (up_down) begin
                if (at_max) begin
                    next_ovf   = 1'b1;
                    next_count = (SATURATE != 0) ? count : '0;
                end else begin
                    next_count = count + ONE;
                end
            end else begin
                if (at_min) begin
                    next_unf   = 1'b1;
                    next_count = (SATURATE != 0) ? count : MAX_CNT;
                end else begin
                    next_count = count - ONE;
                end
            end
        end
    end

    // Count and status registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            count <= next_count;
            ovf   <= next_ovf;
            unf   <= next_unf;
        end
    end

    // Terminal count depends on the current direction, not on enable.
    assign tc = (up_down & at_max) | (~up_down & at_min);

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb/tb_counter_updown_mod.sv - directed bench for counter_updown_mod in three configurations
module tb_counter_updown_mod;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    // a: WIDTH=3 MAX_VAL=5 wrap
    logic       a_en, a_up, a_load, a_tc, a_ovf, a_unf;
    logic [2:0] a_lv, a_count;
    // b: WIDTH=4 MAX_VAL=15 saturate
    logic       b_en, b_up, b_load, b_tc, b_ovf, b_unf;
    logic [3:0] b_lv, b_count;
    // c: WIDTH=4 MAX_VAL=9 wrap
    logic       c_en, c_up, c_load, c_tc, c_ovf, c_unf;
    logic [3:0] c_lv, c_count;

    counter_updown_mod #(.WIDTH(3), .MAX_VAL(5), .SATURATE(0)) u_a (
        .clk(clk), .rst_n(rst_n), .en(a_en), .up_down(a_up), .load(a_load),
        .load_val(a_lv), .count(a_count), .tc(a_tc), .ovf(a_ovf), .unf(a_unf));
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1)) u_b (
        .clk(clk), .rst_n(rst_n), .en(b_en), .up_down(b_up), .load(b_load),
        .load_val(b_lv), .count(b_count), .tc(b_tc), .ovf(b_ovf), .unf(b_unf));
    counter_updown_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) u_c (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up_down(c_up), .load(c_load),
        .load_val(c_lv), .count(c_count), .tc(c_tc), .ovf(c_ovf), .unf(c_unf));

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wrap_c[7]   = '{1, 2, 3, 4, 5, 0, 1};
        int wrap_o[7]   = '{0, 0, 0, 0, 0, 1, 0};
        int wrap_t[7]   = '{0, 0, 0, 0, 1, 0, 0};
        int down_c[3]   = '{0, 5, 4};
        int down_u[3]   = '{0, 1, 0};
        int flip_c[4]   = '{4, 3, 4, 3};

        rst_n = 1'b0;
        a_en = 0; a_up = 1; a_load = 0; a_lv = '0;
        b_en = 0; b_up = 1; b_load = 0; b_lv = '0;
        c_en = 0; c_up = 1; c_load = 0; c_lv = '0;
        repeat (2) step();
        check("reset_count", 32'(a_count), 32'd0);
        check("reset_ovf",   32'(a_ovf),   32'd0);
        check("reset_unf",   32'(a_unf),   32'd0);
        rst_n = 1'b1;

        // asynchronous reset mid-cycle
        a_load = 1; a_lv = 3'd5;
        step();
        check("pre_reset_count", 32'(a_count), 32'd5);
        a_load = 0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_count", 32'(a_count), 32'd0);
        check("async_reset_ovf",   32'(a_ovf),   32'd0);
        rst_n = 1'b1;

        // wrap up through MAX_VAL=5
        a_en = 1; a_up = 1;
        for (int k = 0; k < 7; k++) begin
            step();
            check($sformatf("wrap_up_count_%0d", k), 32'(a_count), 32'(wrap_c[k]));
            check($sformatf("wrap_up_ovf_%0d", k),   32'(a_ovf),   32'(wrap_o[k]));
            check($sformatf("wrap_up_tc_%0d", k),    32'(a_tc),    32'(wrap_t[k]));
        end

        // load 1 (enable ignored), then wrap down
        a_load = 1; a_lv = 3'd1;
        step();
        check("load_one_count", 32'(a_count), 32'd1);
        check("load_one_ovf",   32'(a_ovf),   32'd0);
        a_load = 0; a_up = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("wrap_down_count_%0d", k), 32'(a_count), 32'(down_c[k]));
            check($sformatf("wrap_down_unf_%0d", k),   32'(a_unf),   32'(down_u[k]));
            check($sformatf("wrap_down_ovf_%0d", k),   32'(a_ovf),   32'd0);
        end
        a_en = 0;

        // saturate at 15 going up
        b_load = 1; b_lv = 4'd14;
        step();
        check("sat_load_count", 32'(b_count), 32'd14);
        b_load = 0; b_en = 1; b_up = 1;
        step();
        check("sat_up0_count", 32'(b_count), 32'd15);
        check("sat_up0_ovf",   32'(b_ovf),   32'd0);
        check("sat_up0_tc",    32'(b_tc),    32'd1);
        step();
        check("sat_up1_count", 32'(b_count), 32'd15);
        check("sat_up1_ovf",   32'(b_ovf),   32'd1);
        step();
        check("sat_up2_count", 32'(b_count), 32'd15);
        check("sat_up2_ovf",   32'(b_ovf),   32'd1);
        b_en = 0;
        step();
        check("sat_hold_ovf", 32'(b_ovf), 32'd0);

        // saturate at 0 going down
        b_load = 1; b_lv = 4'd0;
        step();
        b_load = 0; b_en = 1; b_up = 0;
        step();
        check("sat_dn0_count", 32'(b_count), 32'd0);
        check("sat_dn0_unf",   32'(b_unf),   32'd1);
        check("sat_dn0_ovf",   32'(b_ovf),   32'd0);
        step();
        check("sat_dn1_count", 32'(b_count), 32'd0);
        check("sat_dn1_unf",   32'(b_unf),   32'd1);
        b_en = 0;

        // load clamp and priority over enable
        c_load = 1; c_en = 1; c_up = 1; c_lv = 4'd12;
        step();
        check("clamp_count", 32'(c_count), 32'd9);
        check("clamp_ovf",   32'(c_ovf),   32'd0);
        check("clamp_tc",    32'(c_tc),    32'd1);
        c_load = 0; c_en = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            check($sformatf("hold_count_%0d", k), 32'(c_count), 32'd9);
            check($sformatf("hold_ovf_%0d", k),   32'(c_ovf),   32'd0);
        end

        // direction flip every edge
        c_load = 1; c_lv = 4'd3;
        step();
        check("flip_load_count", 32'(c_count), 32'd3);
        c_load = 0; c_en = 1;
        for (int k = 0; k < 4; k++) begin
            c_up = (k % 2 == 0);
            step();
            check($sformatf("flip_count_%0d", k), 32'(c_count), 32'(flip_c[k]));
        end
        c_en = 0;

        // reset clears a pending pulse
        b_en = 1; b_up = 1; b_load = 1; b_lv = 4'd15;
        step();
        b_load = 0;
        step();
        check("pulse_before_reset", 32'(b_ovf), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("pulse_after_reset_ovf",   32'(b_ovf),   32'd0);
        check("pulse_after_reset_count", 32'(b_count), 32'd0);
        rst_n = 1'b1;
        b_en = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
